smem_requester: RTL

//  Core-side initiator for the banked shared memory. One instance per core, attached to that core's

---
 rtl/smem_requester_pkg.sv | 33 +++
 rtl/smem_requester_req_fifo.sv | 53 +++++
 rtl/smem_requester.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/smem_requester_pkg.sv
// Shared widths, request record and FSM encoding for the banked shared-memory requester.
package smem_requester_pkg;

    localparam int SMEM_ADDR_W = 12;
    localparam int SMEM_BANK_W = 4;
    localparam int SMEM_OFF_W  = 8;
    localparam int SMEM_DATA_W = 8;

    typedef struct packed {
        logic                   write;
        logic [SMEM_ADDR_W-1:0] addr;
        logic [SMEM_DATA_W-1:0] data;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    // Address layout: upper nibble selects the bank, low byte is the word offset inside it.
    function automatic logic [SMEM_BANK_W-1:0] bank_of(input logic [SMEM_ADDR_W-1:0] addr);
        return addr[SMEM_ADDR_W-1 -: SMEM_BANK_W];
    endfunction

    function automatic logic [SMEM_OFF_W-1:0] off_of(input logic [SMEM_ADDR_W-1:0] addr);
        return addr[SMEM_OFF_W-1:0];
    endfunction

endpackage

// File: rtl/smem_requester_req_fifo.sv
// Generic request FIFO: push/pop take effect at the clock edge, head is visible combinationally.
// A push is refused when full even if a pop happens in the same cycle; pops on empty are ignored.
module smem_requester_req_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/smem_requester.sv
// Core-side shared-memory initiator: queued loads/stores issued one at a time; push->request 3 cycles, finish->rsp 1 cycle.
// req_ready drops only when the FIFO is full; a watchdog aborts requests the arbiter never finishes.
module smem_requester
    import smem_requester_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [SMEM_ADDR_W-1:0] req_addr_i,
    input  logic [SMEM_DATA_W-1:0] req_wdata_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_write_o,
    output logic [SMEM_DATA_W-1:0] rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [SMEM_ADDR_W-1:0] mem_addr_o,
    output logic [SMEM_DATA_W-1:0] mem_wdata_o,
    input  logic                   mem_finish_i,
    input  logic [SMEM_DATA_W-1:0] mem_rdata_i,
    output logic                   busy_o
);

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t                 state_q,     state_d;
    req_t                   cur_q,       cur_d;
    logic                   mem_rd_q,    mem_rd_d;
    logic                   mem_wr_q,    mem_wr_d;
    logic [WD_W-1:0]        wd_q,        wd_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_write_q, rsp_write_d;
    logic                   rsp_err_q,   rsp_err_d;
    logic [SMEM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    req_t             push_req;
    logic [REQ_W-1:0] head_dat;
    req_t             head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             timeout_hit;

    assign push_req = '{write: req_write_i, addr: req_addr_i, data: req_wdata_i};
    assign head_req = head_dat;

    smem_requester_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .push_i     (req_valid_i),
        .push_dat_i (push_req),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        wd_d        = wd_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cur_d    = head_req;
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_rd_d = ~cur_q.write;
                mem_wr_d = cur_q.write;
                wd_d     = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wd_q != {WD_W{1'b1}}) wd_d = wd_q + WD_W'(1);
                // Finish takes priority over a watchdog expiry landing in the same cycle.
                if (mem_finish_i) begin
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cur_q.write;
                    if (!cur_q.write) rsp_rdata_d = mem_rdata_i;
                    state_d     = ST_GUARD;
                end else if (timeout_hit) begin
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cur_q.write;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // Request bits stay low for a cycle so round robin cannot re-serve this request.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o = ~fifo_full & ~reset_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_read_o  = mem_rd_q;
    assign mem_write_o = mem_wr_q;
    assign mem_addr_o  = cur_q.addr;
    assign mem_wdata_o = cur_q.data;
    assign busy_o      = ~fifo_empty | (state_q != ST_IDLE);

endmodule
